// File: rtl/seg_pkg.sv
// seg_pkg: shared converter states, digit count and 7-segment encodings for seg_scan_display.
package seg_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} conv_state_t;
  localparam int NDIG = 6;
  localparam logic [7:0] DASH = 8'hBF;
  localparam logic [7:0] BLANK = 8'hFF;
  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 8-bit sequential double dabble, one shift/add-3 step per cycle, 8 steps per conversion.
module bin2bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       done,
  output logic [7:0] bcd,
  output logic       over
);
  logic [17:0] sh;
  logic [2:0] cnt;
  logic busy;
  function automatic logic [17:0] step(input logic [17:0] x);
    logic [17:0] y;
    y = x;
    y[11:8] = y[11:8] >= 4'd5 ? y[11:8] + 4'd3 : y[11:8];
    y[15:12] = y[15:12] >= 4'd5 ? y[15:12] + 4'd3 : y[15:12];
    return {y[16:0], 1'b0};
  endfunction
  // The start cycle already performs the first step, so results settle 8 cycles after start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh <= '0;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= busy && cnt == 3'd7;
      if (start) begin
        sh <= step({10'b0, bin});
        cnt <= 3'd1;
        busy <= 1'b1;
      end else if (busy) begin
        sh <= step(sh);
        cnt <= cnt + 3'd1;
        busy <= cnt != 3'd7;
      end
    end
  end
  assign bcd = sh[15:8];
  assign over = |sh[17:16];
endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display: per-frame BCD conversion of hour/minute/second and six-digit multiplexed 7-segment drive.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int SCAN_N = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_minute,
  input  logic [7:0] cur_second,
  output logic [5:0] an,
  output logic [7:0] seg
);
  localparam int SW = $clog2(SCAN_N);
  logic [SW-1:0] scan;
  logic [2:0] idx;
  logic tick, start, done, over;
  conv_state_t state, state_nx;
  logic [4:0] sc;
  logic [7:0] snap_h, snap_m, snap_s, bin, bcd, dig_seg;
  logic [8:0] stg_h, stg_m, disp_h, disp_m, disp_s, nh, nm, ns, fld;
  logic [3:0] digit;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan <= '0;
      idx <= '0;
    end else if (scan == SW'(SCAN_N - 1)) begin
      scan <= '0;
      idx <= idx == 3'(NDIG - 1) ? 3'd0 : idx + 3'd1;
    end else begin
      scan <= scan + 1'b1;
    end
  end
  assign tick = scan == '0 && idx == 3'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = tick ? LOAD : IDLE;
      LOAD:    state_nx = SHIFT;
      SHIFT:   state_nx = sc == 5'd23 ? COMMIT : SHIFT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign start = state == SHIFT && sc[2:0] == 3'd0;
  assign bin = sc[4:3] == 2'd0 ? snap_h : sc[4:3] == 2'd1 ? snap_m : snap_s;
  bin2bcd_seq u_bcd (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bin  (bin),
    .done (done),
    .bcd  (bcd),
    .over (over)
  );
  // The seconds result finishes exactly in COMMIT, so it is taken straight from the converter.
  assign {nh, nm, ns} = state == COMMIT ? {stg_h, stg_m, over, bcd} : {disp_h, disp_m, disp_s};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc <= '0;
      {snap_h, snap_m, snap_s} <= '0;
      {stg_h, stg_m} <= '0;
      {disp_h, disp_m, disp_s} <= '0;
    end else begin
      sc <= state == SHIFT ? sc + 5'd1 : 5'd0;
      if (state == LOAD) {snap_h, snap_m, snap_s} <= {cur_hour, cur_minute, cur_second};
      if (done && state == SHIFT && sc[4:3] == 2'd1) stg_h <= {over, bcd};
      if (done && state == SHIFT && sc[4:3] == 2'd2) stg_m <= {over, bcd};
      {disp_h, disp_m, disp_s} <= {nh, nm, ns};
    end
  end
  always_comb begin
    fld = idx[2:1] == 2'd0 ? nh : idx[2:1] == 2'd1 ? nm : ns;
    digit = idx[0] ? fld[3:0] : fld[7:4];
    dig_seg = (fld[8] ? DASH : seg_enc(digit)) & ((idx == 3'd1 || idx == 3'd3) ? 8'h7F : 8'hFF);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an <= 6'h3F;
      seg <= BLANK;
    end else begin
      an <= ~(6'b100000 >> idx);
      seg <= dig_seg;
    end
  end
endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display: per-cycle scoreboard of an/seg against a decimal-arithmetic model of the display.
module tb_seg_scan_display;
  localparam int SN = 32;
  localparam int FR = 6 * SN;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] cur_hour = '0, cur_minute = '0, cur_second = '0;
  logic [5:0] an;
  logic [7:0] seg;
  seg_scan_display #(.SCAN_N(SN)) dut (
    .clk(clk), .rst(rst), .cur_hour(cur_hour), .cur_minute(cur_minute),
    .cur_second(cur_second), .an(an), .seg(seg)
  );
  always #5 clk = ~clk;
  typedef struct {bit win; logic [5:0] an; logic [7:0] seg;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [23:0] stim[$] = '{{8'd12, 8'd34, 8'd56}, {8'd0, 8'd99, 8'd0}, {8'd23, 8'd100, 8'd59},
                           {8'd255, 8'd0, 8'd99}, {8'd0, 8'd0, 8'd0}};
  logic [7:0] enc[10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int vec = 0, miss = 0, c = 0, p = 0, k = 0, overlap = 0;
  int lowcnt[6] = '{0, 0, 0, 0, 0, 0};
  int sh = 0, sm = 0, ss = 0, dh = 0, dm = 0, ds = 0;
  bit first_run = 1'b1;
  function automatic logic [7:0] exp_seg(input int kk);
    int v;
    logic [7:0] s;
    v = kk < 2 ? dh : kk < 4 ? dm : ds;
    s = v > 99 ? 8'hBF : enc[kk % 2 == 0 ? v / 10 : v % 10];
    return (kk == 1 || kk == 3) ? s & 8'h7F : s;
  endfunction
  task automatic push(input bit w, input logic [5:0] a, input logic [7:0] s);
    q.push_back('{w, a, s});
  endtask
  task automatic rand_in();
    cur_hour = 8'($urandom_range(0, 120));
    cur_minute = 8'($urandom_range(0, 120));
    cur_second = 8'($urandom_range(0, 255));
  endtask
  task automatic next_in();
    if (stim.size() > 0) {cur_hour, cur_minute, cur_second} = stim.pop_front();
    else rand_in();
  endtask
  task automatic cyc();
    @(negedge clk);
    c++;
    p = c % FR;
    if (p == 10) rand_in();
    if (p == 160) next_in();
    if (p == 1) begin sh = cur_hour; sm = cur_minute; ss = cur_second; end
    if (p == 27) begin dh = sh; dm = sm; ds = ss; end
    k = ((c - 1) % FR) / SN;
    push(first_run && c <= 3 * FR, ~(6'b100000 >> k), exp_seg(k));
  endtask
  task automatic hold_rst(input int n);
    @(negedge clk);
    rst = 1'b1;
    push(1'b0, 6'h3F, 8'hFF);
    repeat (n - 1) begin
      @(negedge clk);
      push(1'b0, 6'h3F, 8'hFF);
    end
  endtask
  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    c = 0;
    dh = 0; dm = 0; ds = 0;
    push(1'b0, 6'h3F, 8'hFF);
  endtask
  initial begin
    int target;
    next_in();
    hold_rst(3);
    release_rst();
    repeat (9 * FR) cyc();
    target = c - c % FR + FR + 16;
    while (c != target) cyc();
    hold_rst(4);
    {cur_hour, cur_minute, cur_second} = {8'd7, 8'd8, 8'd9};
    release_rst();
    first_run = 1'b0;
    repeat (3 * FR) cyc();
    @(negedge clk);
    #2;
    vec++;
    if (q.size() != 0) begin
      miss++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    for (int b = 0; b < 6; b++) begin
      vec++;
      if (lowcnt[b] != 3 * SN) begin
        miss++;
        $display("FAIL an_low[%0d]: %0d cycles over 3 frames, expected %0d", b, lowcnt[b], 3 * SN);
      end
    end
    vec++;
    if (overlap != 0) begin
      miss++;
      $display("FAIL an_overlap: %0d cycles with multiple digits on, expected 0", overlap);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
  initial forever begin
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      vec++;
      if (an !== e.an || seg !== e.seg) begin
        miss++;
        $display("FAIL scan c=%0d: an=%h seg=%h expected an=%h seg=%h", c, an, seg, e.an, e.seg);
      end
      if (e.win) begin
        for (int b = 0; b < 6; b++) lowcnt[b] += an[b] ? 0 : 1;
        if ($countones(~an) > 1) overlap++;
      end
    end
  end
endmodule
